// File: rtl/time_display.sv
// Six-digit multiplexed hh.mm.ss display driver: scans active-low common-anode
// digits, latches one time value per frame, and flashes a field or everything.
module time_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] data_t,
  input  logic [1:0]  blink_field,
  input  logic        alarm,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  an
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [2:0]         digit_idx;
  logic               blink_phase;
  logic [23:0]        shadow;

  logic scan_last;
  logic frame_end;
  logic blink_last;

  assign scan_last  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign frame_end  = scan_last && (digit_idx == 3'd5);
  assign blink_last = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      shadow    <= '0;
    end else if (scan_last) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
      // The shadow only changes at the frame boundary so a frame never mixes two times.
      if (frame_end) shadow <= data_t;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_last) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  function automatic logic [6:0] encode_digit(input logic [3:0] value);
    case (value)
      4'd0:    encode_digit = 7'b1000000;
      4'd1:    encode_digit = 7'b1111001;
      4'd2:    encode_digit = 7'b0100100;
      4'd3:    encode_digit = 7'b0110000;
      4'd4:    encode_digit = 7'b0011001;
      4'd5:    encode_digit = 7'b0010010;
      4'd6:    encode_digit = 7'b0000010;
      4'd7:    encode_digit = 7'b1111000;
      4'd8:    encode_digit = 7'b0000000;
      4'd9:    encode_digit = 7'b0010000;
      default: encode_digit = SEG_BLANK;
    endcase
  endfunction

  logic [7:0] field;
  logic [7:0] tens;
  logic [7:0] ones;
  logic       blank;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic [5:0] an_nxt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    field = shadow[23:16];
    case (digit_idx[2:1])
      2'd0:    field = shadow[7:0];
      2'd1:    field = shadow[15:8];
      default: field = shadow[23:16];
    endcase
  end

  assign tens = field / 8'd10;
  assign ones = field % 8'd10;

  // Field n (1..3) covers digit pair n-1; alarm flashes every digit.
  assign blank = !blink_phase &&
                 (alarm || ((blink_field != 2'd0) && (blink_field == digit_idx[2:1] + 2'd1)));

  always_comb begin
    seg_nxt = SEG_BLANK;
    if (blank)                seg_nxt = SEG_BLANK;
    else if (field >= 8'd100) seg_nxt = SEG_DASH;
    else                      seg_nxt = encode_digit(digit_idx[0] ? tens[3:0] : ones[3:0]);
  end

  assign dp_nxt = !((digit_idx == 3'd2) || (digit_idx == 3'd4));
  assign an_nxt = ~(6'b000001 << digit_idx);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= 6'b111111;
    end else begin
      seg <= seg_nxt;
      dp  <= dp_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_time_display.sv
// Randomized bench for time_display; expectations come from a cycle-count model
// that derives digit, blink phase and frame value arithmetically.
module tb_time_display;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 16;
  localparam int FRAME     = 6 * SCAN_DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] data_t = 24'h0;
  logic [1:0]  blink_field = 2'd0;
  logic        alarm = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edges since reset release, and the value captured for the frame.
  int          n_edges = 0;
  logic [23:0] shadow_m = 24'h0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  time_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clock       (clock),
    .reset       (reset),
    .data_t      (data_t),
    .blink_field (blink_field),
    .alarm       (alarm),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n_edges);
    end
  endtask

  // One clock edge: compute expected outputs from the pre-edge model state and
  // current inputs, advance the model, then compare on the falling edge.
  task automatic step();
    int         d;
    int         v;
    bit         visible;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [5:0] e_an;
    d       = (n_edges / SCAN_DIV) % 6;
    visible = ((n_edges / BLINK_DIV) % 2) == 0;
    v       = int'((shadow_m >> (8 * (d / 2))) & 24'hFF);
    if (!visible && (alarm || (int'(blink_field) == d / 2 + 1))) e_seg = 7'b1111111;
    else if (v >= 100)                                          e_seg = 7'b0111111;
    else if (d % 2 == 0)                                        e_seg = seg_tab[v % 10];
    else                                                        e_seg = seg_tab[v / 10];
    e_dp = (d == 2 || d == 4) ? 1'b0 : 1'b1;
    e_an = ~(6'(1) << d);
    @(posedge clock);
    if (n_edges % FRAME == FRAME - 1) shadow_m = data_t;
    n_edges++;
    @(negedge clock);
    check("seg", 32'(seg), 32'(e_seg));
    check("dp",  32'(dp),  32'(e_dp));
    check("an",  32'(an),  32'(e_an));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},  32'(an),  32'h3F);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_dp"},  32'(dp),  32'h1);
  endtask

  initial begin
    data_t = 24'h0C221E;
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b1;

    // Frame 1 shows zeros, frame 2 shows 12:34:30.
    run(2 * FRAME);

    // Minutes flash, then alarm overriding a seconds flash.
    blink_field = 2'd2;
    run(4 * BLINK_DIV);
    blink_field = 2'd1;
    alarm       = 1'b1;
    run(4 * BLINK_DIV);
    alarm       = 1'b0;
    blink_field = 2'd0;

    // Mid-frame data change only appears in the following frame.
    data_t = 24'h000000;
    while (n_edges % FRAME != 10) step();
    data_t = 24'h173B3B;
    run(2 * FRAME);

    // Out-of-range seconds show dashes.
    data_t = 24'h0C2264;
    run(2 * FRAME);

    // Randomized inputs, including out-of-range fields.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        for (int b = 0; b < 3; b++)
          data_t[8*b +: 8] = 8'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 99 : 255));
      end
      if ($urandom_range(0, 19) == 0) blink_field = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) alarm = ~alarm;
      step();
    end
    alarm       = 1'b0;
    blink_field = 2'd0;

    // Asynchronous reset while digit 3 is on the outputs.
    while (((n_edges - 1) / SCAN_DIV) % 6 != 3) step();
    #2 reset = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs("held_rst");
    n_edges  = 0;
    shadow_m = 24'h0;
    reset    = 1'b1;
    run(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_display.md
TIME_DISPLAY -- requirements
Module: time_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit stays selected (>=2).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clock cycles per blink half-period (>=2).
REQ-003 SHALL have port clock  in  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_t  in  24  time: [23:16] hours, [15:8] minutes, [7:0] seconds, unsigned binary.
REQ-006 SHALL have port blink_field  in  2  field to flash: 0 none, 1 seconds, 2 minutes, 3 hours.
REQ-007 SHALL have port alarm  in  1  1 = flash all six digits.
REQ-008 SHALL have port seg  out  7  segments, seg[0]=a to seg[6]=g, active-low.
REQ-009 SHALL have port dp  out  1  decimal point, active-low.
REQ-010 SHALL have port an  out  6  digit enables, one-hot, active-low.

Function
REQ-011 SHALL hold a scan counter 0..SCAN_DIV-1; at SCAN_DIV-1 it returns to 0 and digit index advances 0->1->...->5->0.
REQ-012 SHALL map digit 0 = seconds ones, 1 = seconds tens, 2 = minutes ones, 3 = minutes tens, 4 = hours ones, 5 = hours tens.
REQ-013 SHALL capture data_t into a 24-bit shadow register only on the cycle the digit index wraps 5->0; every frame shows one consistent value.
REQ-014 SHALL split each 8-bit shadow field v into tens = v/10 and ones = v%10 when v<=99.
REQ-015 SHALL show both digits of a field as dash (seg=7'b0111111) when that field v>=100.
REQ-016 SHALL encode seg[6:0] as: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
REQ-017 SHALL drive dp=0 on digits 2 and 4 (hh.mm.ss separators), dp=1 on all others, unaffected by blanking.
REQ-018 SHALL hold a blink counter 0..BLINK_DIV-1 that toggles blink phase at BLINK_DIV-1 and wraps to 0, free-running independent of scan.
REQ-019 SHALL blank seg (1111111) for the two digits of the field selected by blink_field while blink phase=0; blink_field=0 never blanks.
REQ-020 SHALL blank seg on all six digits while alarm=1 and blink phase=0; alarm overrides blink_field.
REQ-021 SHALL sample blink_field and alarm every cycle, unregistered; a change takes effect on the next output register update.
REQ-022 SHALL register seg, dp and an; outputs reflect the digit index and shadow value of the previous cycle (1-cycle latency).
REQ-023 SHALL keep exactly one an bit low in every cycle after the first post-reset clock edge.
REQ-024 SHALL use digit count 6 and field width 8 bits with no arithmetic overflow for any data_t value 0..255 per field.

Reset
REQ-025 SHALL, while reset=0, force scan counter 0, digit index 0, blink counter 0, blink phase 1 (visible), shadow 0.
REQ-026 SHALL, while reset=0, drive an=6'b111111, seg=7'b1111111, dp=1.
REQ-027 SHALL, at the first rising edge after reset release, drive an=6'b111110, seg=1000000 ("0"), dp=1.
REQ-028 SHALL, on reset assertion mid-frame, return to the REQ-025/026 state immediately regardless of clock.

Verification (SCAN_DIV=4, BLINK_DIV=16)
REQ-029 SHALL check: reset release, data_t=0x0C221E (12:34:30) -> frame 1 shows all "0"; from frame 2, digits 0..5 show 0,3,4,3,2,1, each for 4 cycles, dp low on digits 2 and 4.
REQ-030 SHALL check: data_t changes mid-frame from 0x000000 to 0x173B3B -> current frame unchanged; the next frame shows 9,5,9,5,3,2.
REQ-031 SHALL check: seconds field=0x64 (100) -> digits 0 and 1 show 0111111; other fields decode normally.
REQ-032 SHALL check: blink_field=2 -> digits 2 and 3 show 1111111 for 16 cycles, then are visible for 16 cycles, repeating; digits 0,1,4,5 never blank; an still scans.
REQ-033 SHALL check: alarm=1 with blink_field=1 -> all six digits blank during phase 0, all visible during phase 1.
REQ-034 SHALL check: reset asserted while digit 3 is active -> an=111111 and seg=1111111 asynchronously; after release, scanning restarts at digit 0.
